// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Purpose
//   Serial pattern detector. Bits arrive MSB-first on n, qualified by en.
//   A (PAT_LEN-1)-bit history register plus the bit currently presented on n
//   is compared against PATTERN. The detect output d is Mealy: it rises in the
//   same cycle the final pattern bit is presented. Overlapping or
//   non-overlapping detection is selected by OVERLAP. An optional saturating
//   counter reports how many detections occurred since reset.
//
// Parameters
//   PAT_LEN  : pattern length in bits, legal range 2..16
//   PATTERN  : PAT_LEN-bit pattern, PATTERN[PAT_LEN-1] is the first bit received
//   OVERLAP  : 1 = overlapping detection, 0 = non-overlapping detection
//   CNT_W    : width of the match counter
//
// Ports
//   clk       in   1      single clock, all state updates on rising edge
//   rst       in   1      asynchronous active-high reset
//   n         in   1      serial data bit
//   en        in   1      bit-valid, n is consumed only when en=1
//   d         out  1      Mealy detect output (combinational)
//   match_cnt out  CNT_W  detections since reset, saturating
//
// Configuration macro
//   SEQ_DET_COUNT_EN : when defined the saturating match counter is built;
//                      when undefined the counter is compiled out and
//                      match_cnt is tied to zero. d is identical in both builds.
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n,
    input  logic             en,
    output logic             d,
    output logic [CNT_W-1:0] match_cnt
);

    // History holds PAT_LEN-1 bits; the last pattern bit comes straight from n.
    localparam int HIST_W = PAT_LEN - 1;
    // Fill counts 0..PAT_LEN-1; a 1-bit minimum keeps PAT_LEN=2 legal.
    localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [HIST_W-1:0] r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [HIST_W-1:0] w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;

    logic [PAT_LEN-1:0] w_window;   // {history, current bit}, oldest bit in MSB
    logic               w_full;     // history holds PAT_LEN-1 valid bits
    logic               w_hit;      // detection in this cycle

    // Saturating increment of the fill counter.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        logic [FILL_W-1:0] r;
        if (f == FILL_MAX) begin
            r = FILL_MAX;
        end else begin
            r = f + FILL_W'(1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Mealy detect: the window is only meaningful once history is full, which
    // stops reset-zeroed history bits from matching a pattern with leading 0s.
    // -------------------------------------------------------------------------
    assign w_window = {r_hist, n};
    assign w_full   = (r_fill == FILL_MAX);
    assign w_hit    = en & ~rst & w_full & (w_window == PATTERN);
    assign d        = w_hit;

    // Next-state logic for history and fill counter.
    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (en) begin
            if (w_hit && (OVERLAP == 0)) begin
                // Non-overlapping: drop every bit of the completed match.
                w_hist_nxt = '0;
                w_fill_nxt = '0;
            end else begin
                // Lower HIST_W bits of the window are the history shifted left
                // with n in the LSB; this form also works for PAT_LEN=2.
                w_hist_nxt = w_window[HIST_W-1:0];
                w_fill_nxt = fill_inc(r_fill);
            end
        end else begin
            w_hist_nxt = r_hist;
            w_fill_nxt = r_fill;
        end
    end

    // History and fill registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    // -------------------------------------------------------------------------
    // Saturating match counter: updates one edge after d=1, never wraps.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_match_cnt;

    // Match counter register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (w_hit && (r_match_cnt != {CNT_W{1'b1}})) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
        end else begin
            r_match_cnt <= r_match_cnt;
        end
    end

    assign match_cnt = r_match_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param. Three instances share clk and rst:
//   k=0 : defaults (PATTERN 11011, OVERLAP=1, CNT_W=8)
//   k=1 : OVERLAP=0
//   k=2 : OVERLAP=1, CNT_W=2 (counter saturation)
// Only one instance has en=1 at a time; the others hold their state.
// Expected counter values collapse to 0 when SEQ_DET_COUNT_EN is undefined.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       n_v  [3];
    logic       en_v [3];
    logic       d_v  [3];
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detector_param dut_a (
        .clk(clk), .rst(rst), .n(n_v[0]), .en(en_v[0]), .d(d_v[0]), .match_cnt(cnt_a)
    );

    seq_detector_param #(.OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .n(n_v[1]), .en(en_v[1]), .d(d_v[1]), .match_cnt(cnt_b)
    );

    seq_detector_param #(.OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .n(n_v[2]), .en(en_v[2]), .d(d_v[2]), .match_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ecnt(input int v);
        return CNT_ON ? v : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one bit to instance k at the falling edge, check d mid-cycle,
    // let the rising edge consume it, then drop en again.
    task automatic bit_in(input int k, input logic nb, input logic eb,
                          input logic xd, input string tag);
        @(negedge clk);
        n_v[k]  = nb;
        en_v[k] = eb;
        #1;
        chk(tag, {31'd0, d_v[k]}, {31'd0, xd});
        @(posedge clk);
        #1;
        en_v[k] = 1'b0;
        n_v[k]  = 1'b0;
    endtask

    // Reset pulse placed entirely between clock edges.
    task automatic rst_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  pa;
        logic [7:0]  xa;
        logic [10:0] pb;
        logic [10:0] xb;
        logic [13:0] pc;
        logic [13:0] xc;
        int          exp_c [4];
        int          m;

        for (int k = 0; k < 3; k++) begin
            n_v[k]  = 1'b0;
            en_v[k] = 1'b0;
        end
        rst = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_a",   {31'd0, d_v[0]}, 32'd0);
        chk("rst_cnt_a", {24'd0, cnt_a},  32'd0);
        chk("rst_cnt_b", {24'd0, cnt_b},  32'd0);
        chk("rst_cnt_c", {30'd0, cnt_c},  32'd0);
        n_v[0]  = 1'b1;
        en_v[0] = 1'b1;
        #1;
        chk("rst_d_hold", {31'd0, d_v[0]}, 32'd0);
        en_v[0] = 1'b0;
        n_v[0]  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- overlapping, 11011011 ----------------
        pa = 8'b11011011;
        xa = 8'b00001001;
        for (int i = 0; i < 8; i++) begin
            bit_in(0, pa[7-i], 1'b1, xa[7-i], $sformatf("ovl_d_bit%0d", i + 1));
            if (i == 4) chk("ovl_cnt_after5", {24'd0, cnt_a}, ecnt(1));
        end
        chk("ovl_cnt_after8", {24'd0, cnt_a}, ecnt(2));

        // ---------------- non-overlapping, 11011011011 ----------------
        // After the first match history is cleared, so bits 6..11 (011011)
        // complete the next match on bit 11; bit 8 must not match.
        pb = 11'b11011011011;
        xb = 11'b00001000001;
        for (int i = 0; i < 11; i++) begin
            bit_in(1, pb[10-i], 1'b1, xb[10-i], $sformatf("novl_d_bit%0d", i + 1));
        end
        chk("novl_cnt", {24'd0, cnt_b}, ecnt(2));

        // ---------------- stall cycles with en=0 ----------------
        rst_pulse();
        chk("stall_cnt_cleared", {24'd0, cnt_a}, 32'd0);
        bit_in(0, 1'b1, 1'b1, 1'b0, "stall_b1");
        bit_in(0, 1'b1, 1'b1, 1'b0, "stall_b2");
        bit_in(0, 1'b0, 1'b1, 1'b0, "stall_b3");
        bit_in(0, 1'b0, 1'b0, 1'b0, "stall_idle1");
        bit_in(0, 1'b0, 1'b0, 1'b0, "stall_idle2");
        bit_in(0, 1'b1, 1'b1, 1'b0, "stall_b4");
        bit_in(0, 1'b1, 1'b1, 1'b1, "stall_b5");
        chk("stall_cnt", {24'd0, cnt_a}, ecnt(1));

        // ---------------- asynchronous reset mid-sequence ----------------
        rst_pulse();
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_b1");
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_b2");
        bit_in(0, 1'b0, 1'b1, 1'b0, "arst_b3");
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_b4");
        #1 rst = 1'b1;
        n_v[0]  = 1'b1;
        en_v[0] = 1'b1;
        #1;
        chk("arst_d_in_rst",   {31'd0, d_v[0]}, 32'd0);
        chk("arst_cnt_in_rst", {24'd0, cnt_a},  32'd0);
        #1 rst = 1'b0;
        en_v[0] = 1'b0;
        n_v[0]  = 1'b0;
        // Partial match 1101 is gone: a 1 now must not complete it.
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_after1");
        chk("arst_cnt_after1", {24'd0, cnt_a}, 32'd0);
        // History is now 1; 1,1,0,1,1 follows -> 1,1,1,0,1,1, match on last.
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_r1");
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_r2");
        bit_in(0, 1'b0, 1'b1, 1'b0, "arst_r3");
        bit_in(0, 1'b1, 1'b1, 1'b0, "arst_r4");
        bit_in(0, 1'b1, 1'b1, 1'b1, "arst_r5");
        chk("arst_cnt_final", {24'd0, cnt_a}, ecnt(1));

        // ---------------- CNT_W=2 saturation ----------------
        pc = 14'b11011011011011;
        xc = 14'b00001001001001;
        exp_c[0] = 1;
        exp_c[1] = 2;
        exp_c[2] = 3;
        exp_c[3] = 3;
        m = 0;
        for (int i = 0; i < 14; i++) begin
            bit_in(2, pc[13-i], 1'b1, xc[13-i], $sformatf("sat_d_bit%0d", i + 1));
            if (xc[13-i]) begin
                chk($sformatf("sat_cnt_match%0d", m + 1), {30'd0, cnt_c}, ecnt(exp_c[m]));
                m++;
            end
        end
        chk("sat_match_total", m, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
